ipkt_arbiter: RTL

- Merges SpiNNaker packets from two AER input mappers (e.g. retina and cochlea) onto the single 72-bit packet interface feeding the SpiNNaker link driver.
- Grants the inputs round-robin and holds each packet in a registered output stage.
- Discards traffic when the link stops responding, so neither AER device stalls.
- Keeps per-input forwarded and dropped packet counts for the status interface.

---
 rtl/ipkt_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ipkt_arbiter.sv
// ipkt_arbiter
// Merges SpiNNaker packets from two AER input mappers onto the single 72-bit
// packet interface of the SpiNNaker link driver. The two inputs are granted
// round-robin, and each accepted packet is held in a registered output stage.
// If the link stops accepting packets for DUMP_CYCLES cycles, the block
// switches to a dump state. In that state it accepts and discards all input
// traffic, so that neither AER device stalls. Per-input forwarded and dropped
// packet counts are kept for the status interface.
//
// Ports:
//   rst                  asynchronous reset, active-high
//   clk                  clock
//   in0_data/vld/rdy     packet stream from mapper 0 (rdy = accepted this cycle)
//   in1_data/vld/rdy     packet stream from mapper 1
//   out_data/vld         registered packet to the link driver
//   out_rdy              link driver accepts out_data
//   clr_cnt              synchronous clear of all statistics counters
//   dump_mode            registered; high while in the dump state
//   fwd_cnt0/1           packets forwarded per input (saturating)
//   drop_cnt0/1          packets discarded per input (saturating)
module ipkt_arbiter #(
    parameter int DUMP_CYCLES = 128,
    parameter int CNT_BITS    = 16
) (
    input  logic                rst,
    input  logic                clk,
    input  logic [71:0]         in0_data,
    input  logic                in0_vld,
    output logic                in0_rdy,
    input  logic [71:0]         in1_data,
    input  logic                in1_vld,
    output logic                in1_rdy,
    output logic [71:0]         out_data,
    output logic                out_vld,
    input  logic                out_rdy,
    input  logic                clr_cnt,
    output logic                dump_mode,
    output logic [CNT_BITS-1:0] fwd_cnt0,
    output logic [CNT_BITS-1:0] fwd_cnt1,
    output logic [CNT_BITS-1:0] drop_cnt0,
    output logic [CNT_BITS-1:0] drop_cnt1
);

    localparam int CTR_W = $clog2(DUMP_CYCLES + 1);
    localparam logic [CTR_W-1:0] CTR_RELOAD = CTR_W'(DUMP_CYCLES);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               last_r;        // index of the most recently granted input
    logic [CTR_W-1:0]   dump_ctr_r;
    logic               ld_s;
    logic               grant_vld_s;
    logic               grant_idx_s;
    logic               arb_xfer_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] val,
                                                    input logic                en);
        logic [CNT_BITS-1:0] res;
        if (en && (val != {CNT_BITS{1'b1}})) begin
            res = val + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Grant, handshake and next-state decode.
    always_comb begin
        ld_s         = !out_vld || out_rdy;
        grant_vld_s  = in0_vld || in1_vld;
        in0_rdy      = 1'b0;
        in1_rdy      = 1'b0;
        next_state_s = state_r;
        // With both inputs requesting, the input that was not granted last wins.
        if (in0_vld && in1_vld) begin
            grant_idx_s = ~last_r;
        end else begin
            grant_idx_s = in1_vld;
        end
        case (state_r)
            ST_ARB: begin
                in0_rdy = ld_s && grant_vld_s && (grant_idx_s == 1'b0);
                in1_rdy = ld_s && grant_vld_s && (grant_idx_s == 1'b1);
                if ((dump_ctr_r == {CTR_W{1'b0}}) && !out_rdy) begin
                    next_state_s = ST_DUMP;
                end else begin
                    next_state_s = ST_ARB;
                end
            end
            ST_DUMP: begin
                // Both inputs are drained, including in the exit cycle.
                in0_rdy = 1'b1;
                in1_rdy = 1'b1;
                if (out_rdy) begin
                    next_state_s = ST_ARB;
                end else begin
                    next_state_s = ST_DUMP;
                end
            end
            default: begin
                next_state_s = ST_ARB;
            end
        endcase
        arb_xfer_s = (state_r == ST_ARB) && ld_s && grant_vld_s;
    end

    // State register, dump indicator and link-stall watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ARB;
            dump_mode  <= 1'b0;
            dump_ctr_r <= CTR_RELOAD;
        end else begin
            state_r   <= next_state_s;
            dump_mode <= (next_state_s == ST_DUMP);
            if (out_rdy) begin
                dump_ctr_r <= CTR_RELOAD;
            end else if (dump_ctr_r != {CTR_W{1'b0}}) begin
                dump_ctr_r <= dump_ctr_r - {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                dump_ctr_r <= dump_ctr_r;
            end
        end
    end

    // Output packet stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 72'h0;
            out_vld  <= 1'b0;
            last_r   <= 1'b1;
        end else if (state_r == ST_DUMP) begin
            // Any held packet is abandoned; out_data keeps its stale value.
            out_vld <= 1'b0;
        end else if (arb_xfer_s) begin
            out_data <= grant_idx_s ? in1_data : in0_data;
            out_vld  <= 1'b1;
            last_r   <= grant_idx_s;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end else begin
            out_vld <= out_vld;
        end
    end

    // Statistics counters; a clear wins over a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt0  <= {CNT_BITS{1'b0}};
            fwd_cnt1  <= {CNT_BITS{1'b0}};
            drop_cnt0 <= {CNT_BITS{1'b0}};
            drop_cnt1 <= {CNT_BITS{1'b0}};
        end else if (clr_cnt) begin
            fwd_cnt0  <= {CNT_BITS{1'b0}};
            fwd_cnt1  <= {CNT_BITS{1'b0}};
            drop_cnt0 <= {CNT_BITS{1'b0}};
            drop_cnt1 <= {CNT_BITS{1'b0}};
        end else begin
            fwd_cnt0  <= sat_inc(fwd_cnt0,  (state_r == ST_ARB)  && in0_vld && in0_rdy);
            fwd_cnt1  <= sat_inc(fwd_cnt1,  (state_r == ST_ARB)  && in1_vld && in1_rdy);
            drop_cnt0 <= sat_inc(drop_cnt0, (state_r == ST_DUMP) && in0_vld);
            drop_cnt1 <= sat_inc(drop_cnt1, (state_r == ST_DUMP) && in1_vld);
        end
    end

endmodule
